// File: rtl/hps_pkg.sv
// Shared definitions for the harmonic-product-spectrum peak detector.
//   MAG_W   : width of a squared-magnitude sample and of every product
//   state_e : controller states
//   sat32   : saturating truncation of a 64-bit product to MAG_W bits
//   clog2   : bin-index width for a given number of bins
package hps_pkg;

  localparam int unsigned MAG_W = 32;

  typedef enum logic [2:0] {
    StCapture,
    StFetch,
    StAccum,
    StCompare,
    StReport
  } state_e;

  function automatic logic [MAG_W-1:0] sat32(input logic [2*MAG_W-1:0] x);
    return (|x[2*MAG_W-1:MAG_W]) ? {MAG_W{1'b1}} : x[MAG_W-1:0];
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/spectrum_ram.sv
// Single-port frame buffer, synchronous write and one-cycle registered read.
//   i_clock : clock
//   i_we    : write enable (write i_wdata at i_addr)
//   i_addr  : shared read/write address
//   i_wdata : write data
//   o_rdata : data at the address presented on the previous cycle
module spectrum_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 9
) (
  input  logic             i_clock,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/hps_peak_detect.sv
// Harmonic-product-spectrum peak detector. Captures one frame of squared
// magnitudes, then for every candidate k in 1..K multiplies bins k, 2k, ..
// HARMONICS*k (each product shifted right by SHIFT and saturated) and reports
// the candidate with the largest product.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   mag_valid      : magnitude sample present
//   magnitude      : squared magnitude, bins in order 0..BINS-1
//   mag_ready      : high while capturing
//   peak_valid     : one-cycle result pulse
//   peak_bin       : winning candidate, held between pulses
//   peak_value     : winning product, held between pulses
//   overrun        : sticky, a sample was offered while not capturing
module hps_peak_detect
  import hps_pkg::*;
#(
  parameter int unsigned BINS      = 512,
  parameter int unsigned HARMONICS = 3,
  parameter int unsigned SHIFT     = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   mag_valid,
  input  logic [MAG_W-1:0]       magnitude,
  output logic                   mag_ready,
  output logic                   peak_valid,
  output logic [clog2(BINS)-1:0] peak_bin,
  output logic [MAG_W-1:0]       peak_value,
  output logic                   overrun
);

  localparam int unsigned IW = clog2(BINS);
  localparam int unsigned K  = (BINS - 1) / HARMONICS;

  localparam logic [IW-1:0] BIN_LAST = IW'(BINS - 1);
  localparam logic [IW-1:0] K_MAX    = IW'(K);
  localparam logic [2:0]    H_MAX    = 3'(HARMONICS);

  state_e           r_state;
  logic [IW-1:0]    r_bin;
  logic [IW-1:0]    r_k;
  logic [2:0]       r_h;
  // One spare bit: the final addr+=k of a candidate may step past BINS-1.
  logic [IW:0]      r_addr;
  logic [MAG_W-1:0] r_acc;
  logic [MAG_W-1:0] r_best;
  logic [IW-1:0]    r_best_bin;
  logic             r_peak_valid;
  logic [IW-1:0]    r_peak_bin;
  logic [MAG_W-1:0] r_peak_value;
  logic             r_overrun;

  logic             w_capture;
  logic             w_we;
  logic [IW-1:0]    w_ram_addr;
  logic [MAG_W-1:0] w_rdata;
  logic [IW:0]      w_k_ext;
  logic [2*MAG_W-1:0] w_prod;
  logic [2*MAG_W-1:0] w_scaled;
  logic [MAG_W-1:0] w_acc_mul;
  logic             w_better;

  assign w_capture  = (r_state == StCapture);
  assign w_we       = w_capture && mag_valid;
  assign w_ram_addr = w_capture ? r_bin : r_addr[IW-1:0];
  assign w_k_ext    = {1'b0, r_k};
  assign w_prod     = {{MAG_W{1'b0}}, r_acc} * {{MAG_W{1'b0}}, w_rdata};
  assign w_scaled   = w_prod >> SHIFT;
  assign w_acc_mul  = sat32(w_scaled);
  // Strict compare keeps the lowest k on ties.
  assign w_better   = (r_acc > r_best);

  spectrum_ram #(
    .DEPTH (BINS),
    .WIDTH (MAG_W),
    .AW    (IW)
  ) u_ram (
    .i_clock (clock),
    .i_we    (w_we),
    .i_addr  (w_ram_addr),
    .i_wdata (magnitude),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StCapture;
      r_bin        <= '0;
      r_k          <= '0;
      r_h          <= '0;
      r_addr       <= '0;
      r_acc        <= '0;
      r_best       <= '0;
      r_best_bin   <= '0;
      r_peak_valid <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_value <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_peak_valid <= 1'b0;
      if (mag_valid && !w_capture) r_overrun <= 1'b1;

      unique case (r_state)
        StCapture: begin
          if (mag_valid) begin
            r_bin <= r_bin + IW'(1);
            if (r_bin == BIN_LAST) begin
              r_state <= StFetch;
              r_k     <= IW'(1);
              r_h     <= 3'd1;
              r_addr  <= (IW + 1)'(1);
            end
          end
        end
        StFetch: r_state <= StAccum;
        StAccum: begin
          r_acc  <= (r_h == 3'd1) ? w_rdata : w_acc_mul;
          r_addr <= r_addr + w_k_ext;
          if (r_h < H_MAX) begin
            r_h     <= r_h + 3'd1;
            r_state <= StFetch;
          end else begin
            r_state <= StCompare;
          end
        end
        StCompare: begin
          if (w_better) begin
            r_best     <= r_acc;
            r_best_bin <= r_k;
          end
          if (r_k == K_MAX) begin
            // Result registers load here so they change with the pulse in the report cycle.
            r_state      <= StReport;
            r_peak_valid <= 1'b1;
            r_peak_bin   <= w_better ? r_k : r_best_bin;
            r_peak_value <= w_better ? r_acc : r_best;
          end else begin
            r_k     <= r_k + IW'(1);
            r_h     <= 3'd1;
            r_addr  <= w_k_ext + (IW + 1)'(1);
            r_state <= StFetch;
          end
        end
        StReport: begin
          r_best     <= '0;
          r_best_bin <= '0;
          r_bin      <= '0;
          r_state    <= StCapture;
        end
        default: r_state <= StCapture;
      endcase
    end
  end

  assign mag_ready  = w_capture;
  assign peak_valid = r_peak_valid;
  assign peak_bin   = r_peak_bin;
  assign peak_value = r_peak_value;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_hps_peak_detect.sv
module tb_hps_peak_detect;

  localparam int unsigned BINS = 16;
  localparam int unsigned LAT  = 36;  // K=5 candidates * 7 cycles + 1

  logic        clock;
  logic        reset_n;
  logic        mag_valid;
  logic [31:0] magnitude;
  logic        mag_ready;
  logic        peak_valid;
  logic [3:0]  peak_bin;
  logic [31:0] peak_value;
  logic        overrun;

  int total;
  int bad;
  logic exp_ovr;

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [31:0] sval;
    int          sk;
    logic [3:0]  ebin;
    logic [31:0] evalue;
  } vec_t;

  vec_t tab[5];

  hps_peak_detect #(
    .BINS      (16),
    .HARMONICS (3),
    .SHIFT     (0)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mag_valid  (mag_valid),
    .magnitude  (magnitude),
    .mag_ready  (mag_ready),
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_value (peak_value),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bin_val(input vec_t v, input int b);
    if (v.sk != 0 && b > 0 && (b % v.sk) == 0 && (b / v.sk) <= 3) return v.sval;
    return v.base;
  endfunction

  task automatic send_frame(input vec_t v);
    for (int b = 0; b < BINS; b++) begin
      @(posedge clock); #1;
      if (b == 0) check({v.name, " ready_at_start"}, 64'(mag_ready), 64'd1);
      mag_valid = 1'b1;
      magnitude = bin_val(v, b);
    end
  endtask

  // Sends a frame then waits for the result; busy keeps mag_valid high during processing.
  task automatic run_frame(input vec_t v, input bit busy);
    int   n;
    logic ready_ok;
    send_frame(v);
    n = 0;
    ready_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clock); #1;
      if (peak_valid) begin
        n = c;
        mag_valid = 1'b0;
        break;
      end
      if (mag_ready !== 1'b0) ready_ok = 1'b0;
      mag_valid = busy;
      magnitude = 32'hDEAD_BEEF;
    end
    if (mag_ready !== 1'b0) ready_ok = 1'b0;  // still low in the report cycle
    if (busy) exp_ovr = 1'b1;
    check({v.name, " latency"}, 64'(n), 64'(LAT));
    check({v.name, " peak_bin"}, 64'(peak_bin), 64'(v.ebin));
    check({v.name, " peak_value"}, 64'(peak_value), 64'(v.evalue));
    check({v.name, " ready_low_busy"}, 64'(ready_ok), 64'd1);
    @(posedge clock); #1;
    check({v.name, " pulse_one_cycle"}, 64'(peak_valid), 64'd0);
    check({v.name, " ready_back"}, 64'(mag_ready), 64'd1);
    check({v.name, " bin_held"}, 64'(peak_bin), 64'(v.ebin));
    check({v.name, " overrun"}, 64'(overrun), 64'(exp_ovr));
  endtask

  initial begin
    logic seen;
    total = 0;
    bad = 0;
    exp_ovr = 1'b0;
    tab[0] = '{"basic",  32'd1, 32'd2,       4, 4'd4, 32'd8};
    tab[1] = '{"ties",   32'd1, 32'd1,       0, 4'd1, 32'd1};
    tab[2] = '{"zero",   32'd0, 32'd0,       0, 4'd0, 32'd0};
    tab[3] = '{"sat",    32'd1, 32'h10000,   5, 4'd5, 32'hFFFF_FFFF};
    tab[4] = '{"k2",     32'd3, 32'd5,       2, 4'd2, 32'd125};

    reset_n   = 1'b0;
    mag_valid = 1'b0;
    magnitude = '0;
    #23 reset_n = 1'b1;

    // Reset mid-stream.
    for (int b = 0; b < 5; b++) begin
      @(posedge clock); #1;
      mag_valid = 1'b1;
      magnitude = 32'd7;
    end
    @(posedge clock); #1;
    mag_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("rst mag_ready", 64'(mag_ready), 64'd1);
    check("rst peak_valid", 64'(peak_valid), 64'd0);
    check("rst peak_bin", 64'(peak_bin), 64'd0);
    check("rst peak_value", 64'(peak_value), 64'd0);
    check("rst overrun", 64'(overrun), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(tab[i], 1'b0);

    // Overrun: same frame with samples offered during processing, then a clean frame.
    run_frame(tab[0], 1'b1);
    run_frame(tab[4], 1'b0);

    // Abort during FETCH of k=3 (cycle T+15).
    send_frame(tab[0]);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clock); #1;
      mag_valid = 1'b0;
    end
    reset_n = 1'b0;
    exp_ovr = 1'b0;
    @(posedge clock); #1;
    check("abort overrun_cleared", 64'(overrun), 64'd0);
    check("abort ready", 64'(mag_ready), 64'd1);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (peak_valid) seen = 1'b1;
    end
    check("abort no_pulse", 64'(seen), 64'd0);
    run_frame(tab[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
